// File: rtl/dmem_responder.sv
// Data-memory responder: single-cycle core load/store port, a stalling host port for
// preload and dump, and a post-reset sweep that zeroes the array.
module dmem_responder #(
    parameter int unsigned AW = 8,
    parameter int unsigned DW = 8
) (
    input  logic          CLK,
    input  logic          reset,
    input  logic [AW-1:0] DataAddress,
    input  logic          ReadMem,
    input  logic          WriteMem,
    input  logic [DW-1:0] DataIn,
    output logic [DW-1:0] DataOut,
    input  logic          host_req,
    input  logic          host_we,
    input  logic [AW-1:0] host_addr,
    input  logic [DW-1:0] host_wdata,
    output logic [DW-1:0] host_rdata,
    output logic          host_ack,
    output logic          busy,
    output logic          core_err
);

    localparam int unsigned Depth = 2 ** AW;

    typedef enum logic [1:0] {
        StClear,
        StIdle,
        StAck
    } state_e;

    state_e        state_q, state_d;
    logic [AW-1:0] clr_ptr_q, clr_ptr_d;
    logic [DW-1:0] host_rdata_q, host_rdata_d;
    logic          core_err_q, core_err_d;

    logic [DW-1:0] mem [Depth];

    logic          host_grant;
    logic          mem_we;
    logic [AW-1:0] mem_waddr;
    logic [DW-1:0] mem_wdata;

    always_comb begin
        state_d      = state_q;
        clr_ptr_d    = clr_ptr_q;
        host_rdata_d = host_rdata_q;
        core_err_d   = core_err_q;
        host_grant   = 1'b0;
        mem_we       = 1'b0;
        mem_waddr    = DataAddress;
        mem_wdata    = DataIn;

        unique case (state_q)
            StClear: begin
                // Sweep owns the single write port; core writes are dropped.
                mem_we    = 1'b1;
                mem_waddr = clr_ptr_q;
                mem_wdata = '0;
                clr_ptr_d = clr_ptr_q + 1'b1;
                if (ReadMem || WriteMem) begin
                    core_err_d = 1'b1;
                end
                if (clr_ptr_q == '1) begin
                    state_d = StIdle;
                end
            end
            StIdle: begin
                // Core has strict priority: any core strobe stalls the host.
                host_grant = host_req && !ReadMem && !WriteMem;
                if (WriteMem) begin
                    mem_we = 1'b1;
                end else if (host_grant && host_we) begin
                    mem_we    = 1'b1;
                    mem_waddr = host_addr;
                    mem_wdata = host_wdata;
                end
                if (host_grant && !host_we) begin
                    host_rdata_d = mem[host_addr];
                end
                if (host_grant) begin
                    state_d = StAck;
                end
            end
            StAck: begin
                mem_we  = WriteMem;
                state_d = StIdle;
            end
            default: begin
                state_d = StClear;
            end
        endcase
    end

    always_ff @(posedge CLK or posedge reset) begin
        if (reset) begin
            state_q      <= StClear;
            clr_ptr_q    <= '0;
            host_rdata_q <= '0;
            core_err_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            clr_ptr_q    <= clr_ptr_d;
            host_rdata_q <= host_rdata_d;
            core_err_q   <= core_err_d;
        end
    end

    // Array has no reset of its own; the sweep defines its contents.
    always_ff @(posedge CLK) begin
        if (mem_we) begin
            mem[mem_waddr] <= mem_wdata;
        end
    end

    always_comb begin
        DataOut = '0;
        if (ReadMem && state_q != StClear) begin
            DataOut = mem[DataAddress];
        end
    end

    assign host_rdata = host_rdata_q;
    assign host_ack   = (state_q == StAck);
    assign busy       = (state_q == StClear);
    assign core_err   = core_err_q;

endmodule
